// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// and presents {instr, pc, pc+inc} to decode; npc redirects flush the stage.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus,
    output logic        busy
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   fetch_addr_q, fetch_addr_d;
    logic [AW-1:0]   pending_q, pending_d;
    logic            if_valid_q, if_valid_d;
    logic [AW-1:0]   if_instr_q, if_instr_d;
    logic [AW-1:0]   if_pc_q, if_pc_d;
    logic [AW-1:0]   if_pc_plus_q, if_pc_plus_d;
    logic            busy_q, busy_d;

    logic [AW-1:0]   npc_word;
    logic [AW-1:0]   addr_next;

    // Redirect targets are word aligned; sequential increment wraps naturally.
    assign npc_word  = npc & ~AW'(3);
    assign addr_next = fetch_addr_q + AW'(PC_INC);

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pending_d    = pending_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_pc_plus_d = if_pc_plus_q;

        unique case (state_q)
            S_FETCH: begin
                if (imem_ack && npc_valid) begin
                    fetch_addr_d = npc_word;
                end else if (imem_ack) begin
                    if_instr_d   = imem_rdata;
                    if_pc_d      = fetch_addr_q;
                    if_pc_plus_d = addr_next;
                    if_valid_d   = 1'b1;
                    fetch_addr_d = addr_next;
                    state_d      = S_HOLD;
                end else if (npc_valid) begin
                    pending_d = npc_word;
                    state_d   = S_DROP;
                end
            end
            S_HOLD: begin
                if (npc_valid) begin
                    if_valid_d   = 1'b0;
                    fetch_addr_d = npc_word;
                    state_d      = S_FETCH;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = halt ? S_HALT : S_FETCH;
                end
            end
            // Old request still in flight; its data is discarded when it lands.
            S_DROP: begin
                if (imem_ack) begin
                    fetch_addr_d = npc_valid ? npc_word : pending_q;
                    state_d      = S_FETCH;
                end else if (npc_valid) begin
                    pending_d = npc_word;
                end
            end
            S_HALT: begin
                if (npc_valid) begin
                    fetch_addr_d = npc_word;
                    state_d      = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        busy_d = (state_d != S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            fetch_addr_q <= RESET_PC;
            pending_q    <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            if_pc_plus_q <= '0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pending_q    <= pending_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_pc_plus_q <= if_pc_plus_d;
            busy_q       <= busy_d;
        end
    end

    // Request is gated by reset so an abandoned fetch drops immediately.
    assign imem_req   = ((state_q == S_FETCH) || (state_q == S_DROP)) && rst_n;
    assign imem_addr  = fetch_addr_q;
    assign if_valid   = if_valid_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_pc_plus = if_pc_plus_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch stage.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] npc;
    logic        npc_valid;
    logic        halt;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_ready;

    logic        imem_req, if_valid, busy;
    logic [31:0] imem_addr, if_instr, if_pc, if_pc_plus;
    logic        imem_req_1, if_valid_1, busy_1;
    logic [31:0] imem_addr_1, if_instr_1, if_pc_1, if_pc_plus_1;

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .npc(npc), .npc_valid(npc_valid), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus(if_pc_plus), .busy(busy)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .npc(npc), .npc_valid(npc_valid), .halt(halt),
        .imem_req(imem_req_1), .imem_addr(imem_addr_1), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_valid(if_valid_1), .if_ready(if_ready),
        .if_instr(if_instr_1), .if_pc(if_pc_1), .if_pc_plus(if_pc_plus_1), .busy(busy_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an open request (maybe marked for discard), a buffered
    // decode word, or a halted stage.
    bit          m_req_open;
    bit          m_discard;
    bit          m_halted;
    bit          m_out_valid;
    logic [31:0] m_addr, m_pend, m_instr, m_pc, m_pcp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_req_open  = 1'b1;
        m_discard   = 1'b0;
        m_halted    = 1'b0;
        m_out_valid = 1'b0;
        m_addr      = 32'h0;
        m_pend      = 32'h0;
        m_instr     = 32'h0;
        m_pc        = 32'h0;
        m_pcp       = 32'h0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] n, input logic a,
                              input logic [31:0] d, input logic h, input logic r);
        logic [31:0] tgt;
        tgt = {n[31:2], 2'b00};
        if (m_req_open && !m_discard) begin
            if (a && v) begin
                m_addr = tgt;
            end else if (a) begin
                m_out_valid = 1'b1;
                m_instr     = d;
                m_pc        = m_addr;
                m_pcp       = m_addr + 32'd4;
                m_addr      = m_addr + 32'd4;
                m_req_open  = 1'b0;
            end else if (v) begin
                m_discard = 1'b1;
                m_pend    = tgt;
            end
        end else if (m_req_open) begin
            if (a) begin
                m_addr    = v ? tgt : m_pend;
                m_discard = 1'b0;
            end else if (v) begin
                m_pend = tgt;
            end
        end else if (m_out_valid) begin
            if (v) begin
                m_out_valid = 1'b0;
                m_addr      = tgt;
                m_req_open  = 1'b1;
            end else if (r) begin
                m_out_valid = 1'b0;
                if (h) m_halted = 1'b1;
                else   m_req_open = 1'b1;
            end
        end else if (m_halted && v) begin
            m_addr     = tgt;
            m_halted   = 1'b0;
            m_req_open = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("imem_req",   32'(imem_req),  32'(m_req_open & rst_n));
        check("imem_addr",  imem_addr,      m_addr);
        check("if_valid",   32'(if_valid),  32'(m_out_valid));
        check("if_instr",   if_instr,       m_instr);
        check("if_pc",      if_pc,          m_pc);
        check("if_pc_plus", if_pc_plus,     m_pcp);
        check("busy",       32'(busy),      32'(!m_halted));
    endtask

    // Drive at negedge, step the model at posedge, compare at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] n, input logic a,
                         input logic [31:0] d, input logic h, input logic r);
        npc_valid  = v;
        npc        = n;
        imem_ack   = a;
        imem_rdata = d;
        halt       = h;
        if_ready   = r;
        @(posedge clk);
        model_step(v, n, a, d, h, r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; npc = '0; npc_valid = 1'b0; halt = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();
        check("rst_req",      32'(imem_req),   32'd1);
        check("rst_addr",     imem_addr,       32'h0);
        check("rst_valid",    32'(if_valid),   32'd0);
        check("rst_addr_hi",  imem_addr_1,     32'hFFFF_FFFC);
        check("rst_req_hi",   32'(imem_req_1), 32'd1);

        // Back-to-back fetches with same-cycle ack, including the wrapping instance
        cycle(1'b0, 32'h0, 1'b1, 32'hAAAA_0000, 1'b0, 1'b1);
        check("t1_pc0",    if_pc,        32'h0);
        check("t1_pcp0",   if_pc_plus,   32'h4);
        check("t6_pc",     if_pc_1,      32'hFFFF_FFFC);
        check("t6_pcp",    if_pc_plus_1, 32'h0);
        check("t6_valid",  32'(if_valid_1), 32'd1);
        check("t6_instr",  if_instr_1,   32'hAAAA_0000);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t6_addr2",  imem_addr_1,  32'h0);
        check("t6_busy",   32'(busy_1),  32'd1);
        cycle(1'b0, 32'h0, 1'b1, 32'hAAAA_0001, 1'b0, 1'b1);
        check("t1_pc1",    if_pc,        32'h4);
        check("t1_pcp1",   if_pc_plus,   32'h8);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
        check("t1_pc2",    if_pc,        32'h8);
        check("t1_pcp2",   if_pc_plus,   32'hC);

        // Decode stall: stray acks while holding must be ignored
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
            check("t2_valid", 32'(if_valid), 32'd1);
            check("t2_instr", if_instr,      32'hAAAA_0002);
            check("t2_req",   32'(imem_req), 32'd0);
        end
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t2_next", imem_addr, 32'hC);

        // Redirect while a request is outstanding and ack is late
        cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t3_hold0", imem_addr, 32'hC);
        check("t3_req0",  32'(imem_req), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t3_hold1", imem_addr, 32'hC);
        cycle(1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1);
        check("t3_new",   imem_addr, 32'h100);
        check("t3_noval", 32'(if_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 32'hC0DE_0100, 1'b0, 1'b0);
        check("t3_pc",    if_pc,    32'h100);
        check("t3_instr", if_instr, 32'hC0DE_0100);

        // Redirect while holding flushes and aligns the target
        cycle(1'b1, 32'h203, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t4_flush", 32'(if_valid), 32'd0);
        check("t4_addr",  imem_addr,     32'h200);

        // Halt at the decode handshake, then resume via redirect
        cycle(1'b0, 32'h0, 1'b1, 32'h1111_2222, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("t5_req",  32'(imem_req), 32'd0);
        check("t5_busy", 32'(busy),     32'd0);
        cycle(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        check("t5_stay", 32'(busy),     32'd0);
        cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t5_addr", imem_addr,     32'h40);
        check("t5_req1", 32'(imem_req), 32'd1);

        // Reset asserted while a discarded request is in flight
        cycle(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t7_drop", imem_addr, 32'h40);
        rst_n    = 1'b0;
        imem_ack = 1'b1;
        npc_valid = 1'b0;
        #1;
        model_reset();
        check("t7_req",   32'(imem_req), 32'd0);
        check("t7_addr",  imem_addr,     32'h0);
        check("t7_addr1", imem_addr_1,   32'hFFFF_FFFC);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        #1;
        compare_all();
        check("t7_after", imem_addr, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 9) == 0), $urandom,
                  ($urandom_range(0, 2) == 0), $urandom,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
